// File: rtl/design4_bram_multiplier.sv
// Scalar multiplier accelerator: input/output BRAMs with external ports A/B,
// AXI4-Lite register block, and a sequencer computing out[i] = in[i] * coef.
//
// state | meaning
// IDLE  | waiting for START
// RD    | issue engine read of input word at index
// WT    | read data in flight
// WR    | write in*coef to output word at index, advance index
// DONE  | clear busy, set done, return to IDLE
module design4_bram_multiplier #(
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] BRAM_PORTA_addr,
  input  logic [31:0] BRAM_PORTA_din,
  output logic [31:0] BRAM_PORTA_dout,
  input  logic        BRAM_PORTA_en,
  input  logic [3:0]  BRAM_PORTA_we,
  input  logic [31:0] BRAM_PORTB_addr,
  input  logic [31:0] BRAM_PORTB_din,
  output logic [31:0] BRAM_PORTB_dout,
  input  logic        BRAM_PORTB_en,
  input  logic [3:0]  BRAM_PORTB_we,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready
);

  localparam int AW    = ADDR_BITS - 2;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WT,
    S_WR,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [31:0]   mem_in  [DEPTH];
  logic [31:0]   mem_out [DEPTH];
  logic [AW-1:0] a_idx, b_idx;
  logic [AW-1:0] index, n_words;
  logic [AW:0]   idx_inc;
  logic [31:0]   eng_rdata, product;
  logic          eng_we;
  logic          busy, done;

  logic [1:0]  aw_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        reg_wr, start_req, start_go;
  logic [9:0]  len;
  logic [31:0] coef;
  logic [31:0] rd_mux;

  assign a_idx   = BRAM_PORTA_addr[ADDR_BITS-1:2];
  assign b_idx   = BRAM_PORTB_addr[ADDR_BITS-1:2];
  assign busy    = (state != S_IDLE);
  assign product = eng_rdata * coef;
  assign idx_inc = {1'b0, index} + 1'b1;

  // Input BRAM: external port A (read-first) plus engine read port.
  always_ff @(posedge clk) begin
    if (BRAM_PORTA_en) begin
      BRAM_PORTA_dout <= mem_in[a_idx];
      for (int i = 0; i < 4; i++)
        if (BRAM_PORTA_we[i]) mem_in[a_idx][8*i +: 8] <= BRAM_PORTA_din[8*i +: 8];
    end
    if (state == S_RD) eng_rdata <= mem_in[index];
  end

  // Output BRAM: external port B is read-only while the engine owns it.
  always_ff @(posedge clk) begin
    if (BRAM_PORTB_en) begin
      BRAM_PORTB_dout <= mem_out[b_idx];
      if (!busy)
        for (int i = 0; i < 4; i++)
          if (BRAM_PORTB_we[i]) mem_out[b_idx][8*i +: 8] <= BRAM_PORTB_din[8*i +: 8];
    end
    if (eng_we) mem_out[index] <= product;
  end

  // Register write fires once both address and data are held and no response is pending.
  assign reg_wr    = !s_axi_awready && !s_axi_wready && !s_axi_bvalid;
  assign start_req = reg_wr && (aw_addr_q == 2'd0) && w_strb_q[1] && w_data_q[10];
  assign start_go  = start_req && (state == S_IDLE);
  assign s_axi_bresp = 2'b00;
  assign s_axi_rresp = 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b1;
      s_axi_bvalid  <= 1'b0;
      aw_addr_q     <= 2'd0;
      w_data_q      <= 32'd0;
      w_strb_q      <= 4'd0;
      len           <= 10'd0;
      coef          <= 32'd0;
    end else begin
      if (s_axi_awvalid && s_axi_awready) begin
        aw_addr_q     <= s_axi_awaddr[3:2];
        s_axi_awready <= 1'b0;
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_data_q     <= s_axi_wdata;
        w_strb_q     <= s_axi_wstrb;
        s_axi_wready <= 1'b0;
      end
      if (reg_wr) begin
        s_axi_bvalid <= 1'b1;
        case (aw_addr_q)
          2'd0: begin
            if (w_strb_q[0]) len[7:0] <= w_data_q[7:0];
            if (w_strb_q[1]) len[9:8] <= w_data_q[9:8];
          end
          2'd1: begin
            for (int i = 0; i < 4; i++)
              if (w_strb_q[i]) coef[8*i +: 8] <= w_data_q[8*i +: 8];
          end
          default: ;
        endcase
      end
      if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid  <= 1'b0;
        s_axi_awready <= 1'b1;
        s_axi_wready  <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (s_axi_araddr[3:2])
      2'd0:    rd_mux = {20'd0, done, busy, len};
      2'd1:    rd_mux = coef;
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= 32'd0;
    end else if (s_axi_arvalid && s_axi_arready) begin
      s_axi_rdata   <= rd_mux;
      s_axi_rvalid  <= 1'b1;
      s_axi_arready <= 1'b0;
    end else if (s_axi_rvalid && s_axi_rready) begin
      s_axi_rvalid  <= 1'b0;
      s_axi_arready <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      index   <= '0;
      n_words <= '0;
      done    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_go) begin
        n_words <= w_data_q[AW+1:2];
        index   <= '0;
        done    <= 1'b0;
      end else if (state == S_WR) begin
        index <= idx_inc[AW-1:0];
      end
      if (state == S_DONE) done <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    eng_we    = 1'b0;
    case (state)
      S_IDLE: if (start_go) state_nxt = (w_data_q[AW+1:2] == '0) ? S_DONE : S_RD;
      S_RD:   state_nxt = S_WT;
      S_WT:   state_nxt = S_WR;
      S_WR: begin
        eng_we    = 1'b1;
        state_nxt = (idx_inc < {1'b0, n_words}) ? S_RD : S_DONE;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_design4_bram_multiplier.sv
// Directed plus randomized bench for the BRAM multiplier; expected values come
// from a word-array model of both BRAMs and the multiply rule.
module tb_design4_bram_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pa_addr = '0, pa_din = '0, pa_dout;
  logic        pa_en = 1'b0;
  logic [3:0]  pa_we = '0;
  logic [31:0] pb_addr = '0, pb_din = '0, pb_dout;
  logic        pb_en = 1'b0;
  logic [3:0]  pb_we = '0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic        awvalid = 1'b0, awready, wvalid = 1'b0, wready;
  logic [3:0]  wstrb = '0;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready = 1'b0, arvalid = 1'b0, arready, rvalid, rready = 1'b0;

  design4_bram_multiplier dut (
    .clk(clk), .rst_n(rst_n),
    .BRAM_PORTA_addr(pa_addr), .BRAM_PORTA_din(pa_din), .BRAM_PORTA_dout(pa_dout),
    .BRAM_PORTA_en(pa_en), .BRAM_PORTA_we(pa_we),
    .BRAM_PORTB_addr(pb_addr), .BRAM_PORTB_din(pb_din), .BRAM_PORTB_dout(pb_dout),
    .BRAM_PORTB_en(pb_en), .BRAM_PORTB_we(pb_we),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] in_m  [256];
  logic        in_k  [256];
  logic [31:0] out_m [256];
  logic        out_k [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pa_write(input int w, input logic [31:0] d);
    @(negedge clk);
    pa_en = 1'b1; pa_we = 4'hF; pa_addr = 32'(w * 4); pa_din = d;
    @(negedge clk);
    if (in_k[w]) check("porta_read_first", pa_dout, in_m[w]);
    pa_en = 1'b0; pa_we = 4'h0;
    in_m[w] = d; in_k[w] = 1'b1;
  endtask

  task automatic pb_write(input int w, input logic [31:0] d);
    @(negedge clk);
    pb_en = 1'b1; pb_we = 4'hF; pb_addr = 32'(w * 4); pb_din = d;
    @(negedge clk);
    pb_en = 1'b0; pb_we = 4'h0;
  endtask

  task automatic pb_read(input int w, output logic [31:0] d);
    @(negedge clk);
    pb_en = 1'b1; pb_we = 4'h0; pb_addr = 32'(w * 4);
    @(negedge clk);
    d = pb_dout; pb_en = 1'b0;
  endtask

  // mode 0: AW and W together, 1: AW first, 2: W first
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input int mode);
    int t;
    @(negedge clk);
    case (mode)
      1: begin
        awaddr = a; awvalid = 1'b1;
        @(negedge clk); awvalid = 1'b0;
        wdata = d; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk); wvalid = 1'b0;
      end
      2: begin
        wdata = d; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk); wvalid = 1'b0;
        awaddr = a; awvalid = 1'b1;
        @(negedge clk); awvalid = 1'b0;
      end
      default: begin
        awaddr = a; awvalid = 1'b1;
        wdata = d; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk); awvalid = 1'b0; wvalid = 1'b0;
      end
    endcase
    bready = 1'b1;
    t = 0;
    while (!bvalid && t < 20) begin @(negedge clk); t++; end
    check("bvalid", {31'd0, bvalid}, 32'd1);
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
    int t;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    t = 0;
    while (!rvalid && t < 20) begin @(negedge clk); t++; end
    check("rvalid", {31'd0, rvalid}, 32'd1);
    d = rdata;
    @(negedge clk);
    rready = 1'b0;
  endtask

  // Model of one engine run: out[i] = low 32 bits of in[i]*coef for i < len/4.
  task automatic model_run(input logic [31:0] c, input logic [9:0] l);
    logic [63:0] full;
    for (int i = 0; i < int'(l / 4); i++) begin
      full = {32'd0, in_m[i]} * {32'd0, c};
      out_m[i] = full[31:0];
      out_k[i] = 1'b1;
    end
  endtask

  task automatic run(input logic [31:0] c, input logic [9:0] l, input int mode);
    logic [31:0] d;
    axi_write(32'h4, c, mode);
    axi_write(32'h0, {21'd0, 1'b1, l}, mode);
    model_run(c, l);
    repeat (3 * int'(l / 4) + 10) @(negedge clk);
    axi_read(32'h0, d);
    check("status_done", d, {20'd0, 2'b10, l});
  endtask

  task automatic check_out(input int count);
    logic [31:0] d;
    for (int i = 0; i < count; i++)
      if (out_k[i]) begin
        pb_read(i, d);
        check($sformatf("out[%0d]", i), d, out_m[i]);
      end
  endtask

  initial begin
    logic [31:0] d;
    int n, l, c;
    for (int i = 0; i < 256; i++) begin in_k[i] = 1'b0; out_k[i] = 1'b0; end

    repeat (5) @(negedge clk);
    check("rst_rdata", rdata, 32'd0);
    check("rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_readies", {29'd0, awready, wready, arready}, 32'd7);
    rst_n = 1'b1;
    axi_read(32'h0, d);
    check("rst_ctrl", d, 32'd0);
    axi_read(32'h4, d);
    check("rst_coef", d, 32'd0);

    for (int k = 0; k < 8; k++) pa_write(k, 32'(4 * k + 4));
    run(32'd25, 10'h020, 1);
    check_out(8);

    run(32'd10, 10'h020, 0);
    check_out(8);

    pa_write(0, 32'd4);
    pa_write(1, 32'd8);
    run(32'd5, 10'h008, 2);
    check_out(8);

    run(32'd3, 10'h000, 0);
    check_out(8);

    axi_write(32'h8, 32'hFFFF_FFFF, 0);
    axi_read(32'h8, d);
    check("reg8_zero", d, 32'd0);
    axi_read(32'hC, d);
    check("regC_zero", d, 32'd0);
    axi_read(32'h4, d);
    check("coef_kept", d, 32'd3);

    // START while busy is ignored apart from LEN; port B writes blocked while busy.
    pb_write(200, 32'h1111);
    out_m[200] = 32'h1111; out_k[200] = 1'b1;
    axi_write(32'h4, 32'd25, 0);
    axi_write(32'h0, 32'h420, 0);
    model_run(32'd25, 10'h020);
    axi_read(32'h0, d);
    check("status_busy", d, 32'h420);
    axi_write(32'h0, 32'h410, 0);
    pb_write(200, 32'hDEAD);
    axi_read(32'h0, d);
    check("status_busy_len", d, 32'h410);
    repeat (40) @(negedge clk);
    axi_read(32'h0, d);
    check("status_after_busy_start", d, 32'h810);
    check_out(8);
    pb_read(200, d);
    check("portb_blocked", d, 32'h1111);

    // Randomized runs over fresh input data.
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 40);
      for (int k = 0; k < n; k++) pa_write(k, $urandom);
      c = $urandom;
      l = n * 4 + $urandom_range(0, 3);
      run(32'(c), 10'(l), r % 3);
      check_out(n + 1);
    end

    // Reset in the middle of a long run.
    axi_write(32'h4, 32'd7, 0);
    axi_write(32'h0, 32'h500, 0);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 64; i++) out_k[i] = 1'b0;
    @(negedge clk);
    check("midrst_bvalid", {31'd0, bvalid}, 32'd0);
    check("midrst_rvalid", {31'd0, rvalid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    axi_read(32'h0, d);
    check("midrst_ctrl", d, 32'd0);
    axi_read(32'h4, d);
    check("midrst_coef", d, 32'd0);

    for (int k = 0; k < 64; k++) pa_write(k, $urandom);
    run($urandom, 10'h100, 1);
    check_out(64);
    pb_read(200, d);
    check("out200_kept", d, 32'h1111);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/design4_bram_multiplier.md
Name: design4_bram_multiplier

Overview:
Memory-mapped scalar multiplier accelerator. Software loads 32-bit words into an input BRAM through port A and programs a coefficient and a byte length over AXI4-Lite. It then starts the engine. The engine computes out[i] = in[i] * coef for each word and writes the results into an output BRAM, which software reads through port B.

Parameters:
ADDR_BITS, 10, byte-address bits decoded for both BRAMs. Depth is 2^(ADDR_BITS-2) = 256 words of 32 bits.

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst_n  in  1  asynchronous active-low reset
BRAM_PORTA_addr  in  32  input BRAM byte address; bits [ADDR_BITS-1:2] are used, upper bits ignored (addresses wrap)
BRAM_PORTA_din  in  32  input BRAM write data
BRAM_PORTA_dout  out  32  input BRAM read data, 1-cycle latency
BRAM_PORTA_en  in  1  port A enable
BRAM_PORTA_we  in  4  port A byte write enables
BRAM_PORTB_addr  in  32  output BRAM byte address, decoded as for port A
BRAM_PORTB_din  in  32  output BRAM write data
BRAM_PORTB_dout  out  32  output BRAM read data, 1-cycle latency
BRAM_PORTB_en  in  1  port B enable
BRAM_PORTB_we  in  4  port B byte write enables
s_axi_awaddr  in  32  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  write strobes
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response, always 2'b00
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  32  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response, always 2'b00
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready

Behaviour:
- Reset values: all AXI valid outputs 0; awready, wready and arready 1; rdata 0; CTRL = 0; COEF = 0; busy and done 0; engine IDLE. BRAM contents are not reset.
- Port A: when en=1, the bytes enabled by we are written to the input BRAM, and dout returns the old word one cycle later (read-first).
- Port B: the same rules apply to the output BRAM. Port B writes are ignored while busy=1.
- AXI write channel:
  - The AW and W channels are accepted independently, in either order or together. awready drops after an address is captured; wready drops after data is captured.
  - The register write occurs in the cycle both are held, honouring wstrb.
  - bvalid is then asserted and held until bready. awready and wready return to 1 after the B handshake.
- AXI read channel:
  - An AR handshake when arready=1 registers rdata and sets rvalid on the next edge. arready stays 0 until the rvalid/rready handshake.
- Register map, decoded on addr[3:2]:
  - 0x0 CTRL write: bits[9:0] LEN in bytes; bit10 START.
  - 0x0 read: bits[9:0] LEN, bit10 busy, bit11 done (sticky), all other bits 0.
  - 0x4 COEF, 32-bit read/write.
  - 0x8 and 0xC read 0; writes to them are ignored.
- START handling:
  - START is self-clearing.
  - START with busy=0 clears done, sets busy, loads word count N = LEN>>2 (LEN[1:0] ignored), and resets the word index to 0.
  - START while busy=1 is ignored; the LEN field is still updated.
- Engine FSM, IDLE -> RD -> WT -> WR:
  - RD drives internal read address = index on the input BRAM.
  - WT waits one cycle for the read data.
  - WR writes lower 32 bits of (unsigned dout * COEF) to output BRAM[index] and increments index.
  - After WR: back to RD while index < N, otherwise go to DONE.
  - DONE clears busy, sets done, and returns to IDLE.
  - Cost is 3 cycles per word; N=0 goes straight to DONE on the cycle after START.
- Engine memory access: the engine uses a dedicated internal port on each BRAM, so external ports A and B stay usable concurrently. A same-address collision on the input BRAM returns the old data to the engine.
- COEF is sampled each WR cycle, so software must not change it while busy=1.
- rst_n asserted mid-operation aborts the engine immediately. The output BRAM keeps its partially written contents.

Test Plan:
- Reset 5 cycles, then read 0x0 -> rdata=0, bvalid=0, rvalid=0 before the access.
- Port A write in[k]=4k+4 for k=0..7. Write COEF=25 (AW one cycle, W next cycle), then CTRL=0x420. Wait 50 cycles, read 0x0 -> 0x820. Port B reads of bytes 0..28 -> 100,200,...,800.
- Same inputs, COEF=10, CTRL=0x420 -> out = 40,80,...,320; status 0x820.
- Rewrite words 0..1 only, COEF=5, CTRL=0x408 -> out[0]=20, out[1]=40; out[2..7] unchanged at 120..320; status 0x808.
- COEF=3, CTRL=0x400 (LEN=0) -> done on the next cycle, no output writes; status 0x800.
- START issued while busy -> ignored; results match the first run. Reset asserted mid-run -> busy=0, done=0, CTRL=0.
